// File: rtl/kgp_pkg.sv
// kgp_pkg: shared constants for the KGP-RISC datapath.
//   XLEN          datapath width
//   BR_*          branch opcode encoding carried on br_op
//   FLG_*         bit positions inside the {C,Z,S,V} flag vector
package kgp_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] BR_B    = 4'd0;
  localparam logic [3:0] BR_BR   = 4'd1;
  localparam logic [3:0] BR_BZ   = 4'd2;
  localparam logic [3:0] BR_BNZ  = 4'd3;
  localparam logic [3:0] BR_BCY  = 4'd4;
  localparam logic [3:0] BR_BNCY = 4'd5;
  localparam logic [3:0] BR_BS   = 4'd6;
  localparam logic [3:0] BR_BNS  = 4'd7;
  localparam logic [3:0] BR_BV   = 4'd8;
  localparam logic [3:0] BR_BNV  = 4'd9;
  localparam logic [3:0] BR_CALL = 4'd10;
  localparam logic [3:0] BR_RET  = 4'd11;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_S = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational branch condition evaluator.
//   br_op  in  4  branch opcode
//   flags  in  4  {C,Z,S,V}
//   cond   out 1  condition true for this opcode (reserved codes -> 0)
module branch_cond
  import kgp_pkg::*;
(
  input  logic [3:0] br_op,
  input  logic [3:0] flags,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (br_op)
      BR_B, BR_BR, BR_CALL, BR_RET: cond = 1'b1;
      BR_BZ:   cond =  flags[FLG_Z];
      BR_BNZ:  cond = ~flags[FLG_Z];
      BR_BCY:  cond =  flags[FLG_C];
      BR_BNCY: cond = ~flags[FLG_C];
      BR_BS:   cond =  flags[FLG_S];
      BR_BNS:  cond = ~flags[FLG_S];
      BR_BV:   cond =  flags[FLG_V];
      BR_BNV:  cond = ~flags[FLG_V];
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register, flag register and branch resolution.
//   clk, rst          clock, synchronous active-high reset
//   stall             hold pc/flags/misalign, suppress link_we
//   flags_we/in       flag register load
//   br_en/op/offset   branch request; reg_target feeds br/ret
//   pc, pc_plus4      current PC and sequential successor
//   br_target, taken  resolved target and next-PC mux select
//   link_addr/we      return address write for call
//   flags, misalign   registered flags, sticky misaligned-target error
module pc_next_unit
  import kgp_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flags_we,
  input  logic [3:0]      flags_in,
  input  logic            br_en,
  input  logic [3:0]      br_op,
  input  logic [XLEN-1:0] br_offset,
  input  logic [XLEN-1:0] reg_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] br_target,
  output logic            taken,
  output logic [XLEN-1:0] link_addr,
  output logic            link_we,
  output logic [3:0]      flags,
  output logic            misalign
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      flags_q, flags_d;
  logic            misalign_q, misalign_d;
  logic            cond;

  // Conditions always see the registered flags, so a same-cycle flags_we
  // only affects the following instruction.
  branch_cond u_cond (
    .br_op (br_op),
    .flags (flags_q),
    .cond  (cond)
  );

  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    br_target  = (br_op == BR_BR || br_op == BR_RET) ? reg_target : pc_q + br_offset;
    taken      = br_en & cond;
    link_addr  = pc_plus4;
    link_we    = br_en & (br_op == BR_CALL) & ~stall;

    pc_d       = pc_q;
    flags_d    = flags_q;
    misalign_d = misalign_q;
    if (!stall) begin
      // Low bits are dropped so the PC stays word-aligned; the error is
      // remembered separately in misalign.
      pc_d = taken ? {br_target[XLEN-1:2], 2'b00} : pc_plus4;
      if (flags_we) flags_d = flags_in;
      if (taken && br_target[1:0] != 2'b00) misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      flags_q    <= 4'b0000;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      flags_q    <= flags_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign flags    = flags_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flags_we, br_en;
  logic [3:0]  flags_in, br_op;
  logic [31:0] br_offset, reg_target;
  logic [31:0] pc, pc_plus4, br_target, link_addr;
  logic        taken, link_we, misalign;
  logic [3:0]  flags;

  int n_chk  = 0;
  int n_pass = 0;

  // reference state
  logic [31:0] m_pc;
  logic [3:0]  m_flags;
  logic        m_mis;

  always #5 clk = ~clk;

  pc_next_unit #(.RESET_VEC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flags_we(flags_we), .flags_in(flags_in),
    .br_en(br_en), .br_op(br_op), .br_offset(br_offset), .reg_target(reg_target),
    .pc(pc), .pc_plus4(pc_plus4), .br_target(br_target), .taken(taken),
    .link_addr(link_addr), .link_we(link_we), .flags(flags), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Conditional ops come in (true, negated) pairs starting at 2: Z, C, S, V.
  function automatic logic ref_cond(input logic [3:0] op, input logic [3:0] f);
    logic fb;
    if (op == 4'd0 || op == 4'd1 || op == 4'd10 || op == 4'd11) return 1'b1;
    if (op < 4'd2 || op > 4'd9) return 1'b0;
    case ((int'(op) - 2) / 2)
      0:       fb = f[2];
      1:       fb = f[3];
      2:       fb = f[1];
      default: fb = f[0];
    endcase
    return op[0] ? ~fb : fb;
  endfunction

  // One clock: drive inputs, check everything against the model, then
  // advance model and DUT together.
  task automatic cyc(input logic r, input logic s, input logic fwe, input logic [3:0] fin,
                     input logic ben, input logic [3:0] op,
                     input logic [31:0] off, input logic [31:0] tgt);
    logic        e_tk;
    logic [31:0] e_tgt, e_p4;
    rst = r; stall = s; flags_we = fwe; flags_in = fin;
    br_en = ben; br_op = op; br_offset = off; reg_target = tgt;
    #1;
    e_tk  = ben & ref_cond(op, m_flags);
    e_tgt = (op == 4'd1 || op == 4'd11) ? tgt : m_pc + off;
    e_p4  = m_pc + 32'd4;
    chk("pc",        pc,        m_pc);
    chk("flags",     {28'd0, flags}, {28'd0, m_flags});
    chk("misalign",  {31'd0, misalign}, {31'd0, m_mis});
    chk("pc_plus4",  pc_plus4,  e_p4);
    chk("taken",     {31'd0, taken}, {31'd0, e_tk});
    chk("br_target", br_target, e_tgt);
    chk("link_addr", link_addr, e_p4);
    chk("link_we",   {31'd0, link_we}, {31'd0, (ben && op == 4'd10 && !s)});
    if (r) begin
      m_pc = 32'h0; m_flags = 4'h0; m_mis = 1'b0;
    end else if (!s) begin
      if (e_tk && e_tgt[1:0] != 2'b00) m_mis = 1'b1;
      m_pc = e_tk ? (e_tgt & 32'hFFFF_FFFC) : e_p4;
      if (fwe) m_flags = fin;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flags_we = 1'b0; flags_in = 4'h0;
    br_en = 1'b0; br_op = 4'h0; br_offset = 32'h0; reg_target = 32'h0;
    @(posedge clk); #1;
    m_pc = 32'h0; m_flags = 4'h0; m_mis = 1'b0;
    rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 3; i++) begin
      chk("idle_pc", pc, 32'(4 * i));
      idle();
    end
    chk("idle_pc3", pc, 32'd12);
    chk("rst_flags", {28'd0, flags}, 32'd0);

    // BZ / BNZ with Z set
    cyc(0, 0, 1, 4'b0100, 1, 4'd1, 32'h0, 32'h1C);      // BR 0x1C, load Z
    idle();                                               // pc 0x20
    chk("pre_bz_pc", pc, 32'h20);
    cyc(0, 0, 0, 4'h0, 1, 4'd2, 32'hFFFF_FFF8, 32'h0);  // BZ -8
    chk("bz_pc", pc, 32'h18);
    cyc(0, 0, 0, 4'h0, 1, 4'd1, 32'h0, 32'h20);         // back to 0x20
    cyc(0, 0, 0, 4'h0, 1, 4'd3, 32'hFFFF_FFF8, 32'h0);  // BNZ -8: not taken
    chk("bnz_pc", pc, 32'h24);

    // CALL / RET
    cyc(0, 0, 0, 4'h0, 1, 4'd1, 32'h0, 32'h100);
    chk("call_link", link_addr, 32'h104);
    cyc(0, 0, 0, 4'h0, 1, 4'd10, 32'h40, 32'h0);
    chk("call_pc", pc, 32'h140);
    cyc(0, 0, 0, 4'h0, 1, 4'd11, 32'h0, 32'h104);
    chk("ret_pc", pc, 32'h104);

    // same-cycle flag load uses old C
    cyc(0, 0, 1, 4'b1000, 1, 4'd4, 32'h10, 32'h0);
    chk("bcy_old_pc", pc, 32'h108);
    cyc(0, 0, 0, 4'h0, 1, 4'd4, 32'h10, 32'h0);
    chk("bcy_new_pc", pc, 32'h118);

    // misaligned register target is sticky
    cyc(0, 0, 0, 4'h0, 1, 4'd1, 32'h0, 32'h203);
    chk("mis_pc", pc, 32'h200);
    chk("mis_set", {31'd0, misalign}, 32'd1);
    cyc(0, 0, 0, 4'h0, 1, 4'd0, 32'h8, 32'h0);
    chk("mis_hold", {31'd0, misalign}, 32'd1);

    // stall during CALL, then reset while stalled
    cyc(0, 1, 1, 4'b0001, 1, 4'd10, 32'h40, 32'h0);
    cyc(0, 1, 1, 4'b0001, 1, 4'd10, 32'h40, 32'h0);
    chk("stall_pc", pc, 32'h208);
    chk("stall_flags", {28'd0, flags}, 32'h8);
    cyc(1, 1, 1, 4'b0001, 1, 4'd10, 32'h40, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);

    // pc_plus4 wrap
    cyc(0, 0, 0, 4'h0, 1, 4'd1, 32'h0, 32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus4, 32'h0);
    idle();
    chk("wrap_pc", pc, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] off, tgt;
      off = $urandom_range(0, 9) == 0 ? $urandom : (32'($urandom_range(0, 255)) - 32'd128) << 2;
      tgt = $urandom_range(0, 7) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          4'($urandom), $urandom_range(0, 3) != 0, 4'($urandom), off, tgt);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
